sync_filter_edge: RTL and testbench

Multi-channel successor to the single-bit synchronizer: brings NCH asynchronous inputs (front-panel lines, GPS PPS, external triggers) into the `out_clk` domain through an NSYNC-stage chain per channel. Each synchronized channel then passes a programmable stability filter and produces rise/fall pulses and a sticky event flag with overflow for CPU or state-machine polling. It sits at the FPGA pin boundary, in front of any logic that consumes external asynchronous levels or edges.

---
 rtl/sync_filter_edge.sv | 105 ++++++++++
 tb/tb_sync_filter_edge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_edge.sv
// sync_filter_edge: per-channel multi-stage synchronizer for asynchronous
// input levels, followed by a stability filter and edge detection. Each
// channel produces a filtered level, one-cycle rise/fall pulses and a sticky
// event flag with overflow for software or state-machine polling.
module sync_filter_edge #(
    parameter int             NCH      = 1,
    parameter int             NSYNC    = 2,
    parameter int             NFILT    = 0,
    parameter logic [NCH-1:0] RST_VAL  = {NCH{1'b0}},
    parameter int             EVT_MODE = 0
) (
    input  logic           out_clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] in,
    input  logic [NCH-1:0] clr_evt,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] evt,
    output logic [NCH-1:0] ovf
);

    // Filter counter is at least one bit wide even when filtering is disabled.
    localparam int            CW   = (NFILT > 0) ? $clog2(NFILT + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(NFILT);

    if (EVT_MODE < 0 || EVT_MODE > 2) begin : g_bad_evt_mode
        $error("sync_filter_edge: EVT_MODE must be 0, 1 or 2");
    end

    if (NSYNC < 2) begin : g_bad_nsync
        $error("sync_filter_edge: NSYNC must be at least 2");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0] sync_q;
        logic [CW-1:0] cnt;
        logic          out_q;
        logic          rise_q;
        logic          fall_q;
        logic          evt_q;
        logic          ovf_q;
        logic          s;
        logic          change;
        logic          q;

        assign s = sync_q[NSYNC-1];

        // The level has been different for NFILT+1 consecutive edges.
        assign change = (s != out_q) && (cnt == CMAX);

        // Edges that count as events for this build.
        assign q = (EVT_MODE == 1) ? rise_q :
                   (EVT_MODE == 2) ? fall_q :
                                     (rise_q | fall_q);

        // Synchronizer chain: the input enters stage 0 and shifts toward the last stage.
        always_ff @(posedge out_clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {NSYNC{RST_VAL[c]}};
            end else begin
                sync_q <= {sync_q[NSYNC-2:0], in[c]};
            end
        end

        // Stability filter: out follows s only after a persistent difference; pulses mark the change.
        always_ff @(posedge out_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                out_q  <= RST_VAL[c];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= change & s;
                fall_q <= change & ~s;
                if (change) begin
                    out_q <= s;
                end
                if ((s == out_q) || change) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // Sticky event and overflow: a clear never swallows a coincident new event.
        always_ff @(posedge out_clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                evt_q <= q | (evt_q & ~clr_evt[c]);
                ovf_q <= ~clr_evt[c] & (ovf_q | (q & evt_q));
            end
        end

        assign out[c]  = out_q;
        assign rise[c] = rise_q;
        assign fall[c] = fall_q;
        assign evt[c]  = evt_q;
        assign ovf[c]  = ovf_q;
    end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Testbench for sync_filter_edge: two instances (any-edge events and
// fall-only events) share the same inputs and are compared against a
// window-based reference model plus directed constant expectations.
module tb_sync_filter_edge;

    localparam int         NCH     = 4;
    localparam int         NSYNC   = 2;
    localparam int         NFILT   = 3;
    localparam logic [3:0] RST_VAL = 4'b0101;
    localparam int         W       = NSYNC + NFILT + 1;

    logic       out_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic [3:0] in_v;
    logic [3:0] clr_v;

    logic [3:0] out_a, rise_a, fall_a, evt_a, ovf_a;
    logic [3:0] out_b, rise_b, fall_b, evt_b, ovf_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] hist [$];
    logic [3:0] m_out, m_rise, m_fall, m_evt0, m_ovf0, m_evt2, m_ovf2;

    always #5 out_clk = ~out_clk;

    sync_filter_edge #(
        .NCH(NCH), .NSYNC(NSYNC), .NFILT(NFILT), .RST_VAL(RST_VAL), .EVT_MODE(0)
    ) dut_any (
        .out_clk(out_clk), .rst_n(rst_n), .in(in_v), .clr_evt(clr_v),
        .out(out_a), .rise(rise_a), .fall(fall_a), .evt(evt_a), .ovf(ovf_a)
    );

    sync_filter_edge #(
        .NCH(NCH), .NSYNC(NSYNC), .NFILT(NFILT), .RST_VAL(RST_VAL), .EVT_MODE(2)
    ) dut_fall (
        .out_clk(out_clk), .rst_n(rst_n), .in(in_v), .clr_evt(clr_v),
        .out(out_b), .rise(rise_b), .fall(fall_b), .evt(evt_b), .ovf(ovf_b)
    );

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < W; i++) hist.push_back(RST_VAL);
        m_out  = RST_VAL;
        m_rise = '0; m_fall = '0;
        m_evt0 = '0; m_ovf0 = '0;
        m_evt2 = '0; m_ovf2 = '0;
    endtask

    // One clock edge of the model: out flips when the synchronized level
    // (input delayed NSYNC samples) has differed from out on the last NFILT+1 edges.
    task automatic model_update();
        logic [3:0] q0, q2, chg;
        q0 = m_rise | m_fall;
        q2 = m_fall;
        m_ovf0 = ~clr_v & (m_ovf0 | (q0 & m_evt0));
        m_evt0 = q0 | (m_evt0 & ~clr_v);
        m_ovf2 = ~clr_v & (m_ovf2 | (q2 & m_evt2));
        m_evt2 = q2 | (m_evt2 & ~clr_v);
        hist.push_back(in_v);
        void'(hist.pop_front());
        chg = 4'hF;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i <= NFILT; i++)
                if (hist[W-1-NSYNC-i][c] == m_out[c]) chg[c] = 1'b0;
        m_rise = chg & ~m_out;
        m_fall = chg & m_out;
        m_out  = m_out ^ chg;
    endtask

    task automatic tick();
        @(posedge out_clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_a, rise_a, fall_a, evt_a, ovf_a} !== {RST_VAL, 16'h0}) begin
            errors++;
            $display("FAIL reset_any: got %h expected %h", {out_a, rise_a, fall_a, evt_a, ovf_a}, {RST_VAL, 16'h0});
        end
        checks++;
        if ({out_b, rise_b, fall_b, evt_b, ovf_b} !== {RST_VAL, 16'h0}) begin
            errors++;
            $display("FAIL reset_fall: got %h expected %h", {out_b, rise_b, fall_b, evt_b, ovf_b}, {RST_VAL, 16'h0});
        end
        @(negedge out_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if ({out_a, rise_a | fall_a | evt_a | evt_b} !== {RST_VAL, 4'h0}) begin
                errors++;
                $display("FAIL idle cycle %0d: got out=%b pulses/evt=%b expected out=%b none", k, out_a, rise_a | fall_a | evt_a | evt_b, RST_VAL);
            end
        end
    endtask

    task automatic test_latency();
        in_v[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (out_a[1] !== (k >= 6) || rise_a[1] !== (k == 6) || evt_a[1] !== (k >= 7) || evt_b[1] !== 1'b0) begin
                errors++;
                $display("FAIL latency edge %0d: got out=%b rise=%b evt=%b evt_fall=%b expected out=%b rise=%b evt=%b evt_fall=0",
                         k, out_a[1], rise_a[1], evt_a[1], evt_b[1], k >= 6, k == 6, k >= 7);
            end
        end
    endtask

    task automatic test_glitch();
        int nr, nf;
        in_v[3] = 1'b1;
        tick(); tick(); tick();
        in_v[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (out_a[3] !== 1'b0 || rise_a[3] !== 1'b0 || fall_a[3] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d: got out=%b rise=%b fall=%b expected 0 0 0", k, out_a[3], rise_a[3], fall_a[3]);
            end
        end
        nr = 0; nf = 0;
        in_v[3] = 1'b1;
        tick(); nr += rise_a[3]; nf += fall_a[3];
        tick(); nr += rise_a[3]; nf += fall_a[3];
        tick(); nr += rise_a[3]; nf += fall_a[3];
        tick(); nr += rise_a[3]; nf += fall_a[3];
        in_v[3] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            nr += rise_a[3];
            nf += fall_a[3];
        end
        checks++;
        if (nr != 1 || nf != 1) begin
            errors++;
            $display("FAIL glitch_pass: got rises=%0d falls=%0d expected 1 1", nr, nf);
        end
        checks++;
        if (evt_a[3] !== 1'b1 || ovf_a[3] !== 1'b1) begin
            errors++;
            $display("FAIL two_edges_sticky: got evt=%b ovf=%b expected 1 1", evt_a[3], ovf_a[3]);
        end
    endtask

    task automatic test_sticky();
        clr_v = 4'b1000;
        tick();
        clr_v = 4'b0000;
        checks++;
        if (evt_a[3] !== 1'b0 || ovf_a[3] !== 1'b0 || evt_b[3] !== 1'b0) begin
            errors++;
            $display("FAIL clear: got evt=%b ovf=%b evt_fall=%b expected 0 0 0", evt_a[3], ovf_a[3], evt_b[3]);
        end
        in_v[3] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (evt_a[3] !== 1'b1 || ovf_a[3] !== 1'b0) begin
            errors++;
            $display("FAIL single_edge: got evt=%b ovf=%b expected 1 0", evt_a[3], ovf_a[3]);
        end
        in_v[3] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        clr_v = 4'b1000;
        tick();
        clr_v = 4'b0000;
        checks++;
        if (evt_a[3] !== 1'b1 || ovf_a[3] !== 1'b0 || evt_b[3] !== 1'b1 || ovf_b[3] !== 1'b0) begin
            errors++;
            $display("FAIL clear_coincident: got evt=%b ovf=%b evt_fall=%b ovf_fall=%b expected 1 0 1 0",
                     evt_a[3], ovf_a[3], evt_b[3], ovf_b[3]);
        end
    endtask

    task automatic test_mode();
        int nr;
        clr_v = 4'b1000;
        tick();
        clr_v = 4'b0000;
        nr = 0;
        in_v[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            nr += rise_b[3];
        end
        checks++;
        if (nr != 1 || evt_b[3] !== 1'b0) begin
            errors++;
            $display("FAIL mode_fall_on_rise: got rises=%0d evt=%b expected 1 0", nr, evt_b[3]);
        end
        in_v[3] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (fall_b[3] !== 1'b1 || evt_b[3] !== 1'b0) begin
            errors++;
            $display("FAIL mode_fall_pulse: got fall=%b evt=%b expected 1 0", fall_b[3], evt_b[3]);
        end
        tick();
        checks++;
        if (evt_b[3] !== 1'b1 || evt_a[3] !== 1'b1) begin
            errors++;
            $display("FAIL mode_fall_evt: got evt_fall=%b evt_any=%b expected 1 1", evt_b[3], evt_a[3]);
        end
    endtask

    task automatic test_reset_mid();
        in_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (out_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_filter_hold: got out=%b expected 1", out_a[0]);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_a, rise_a, fall_a, evt_a, ovf_a, evt_b, ovf_b} !== {RST_VAL, 24'h0}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", {out_a, rise_a, fall_a, evt_a, ovf_a, evt_b, ovf_b}, {RST_VAL, 24'h0});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (out_a[0] !== (k < 6) || fall_a[0] !== (k == 6)) begin
                errors++;
                $display("FAIL repropagate edge %0d: got out=%b fall=%b expected out=%b fall=%b", k, out_a[0], fall_a[0], k < 6, k == 6);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(5) == 0) in_v[c] = ~in_v[c];
                clr_v[c] = ($urandom_range(15) == 0);
            end
            if (i == 1500) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
            checks++;
            if ({out_a, rise_a, fall_a, evt_a, ovf_a} !== {m_out, m_rise, m_fall, m_evt0, m_ovf0}) begin
                errors++;
                $display("FAIL random_any cycle %0d: got %h expected %h", i, {out_a, rise_a, fall_a, evt_a, ovf_a}, {m_out, m_rise, m_fall, m_evt0, m_ovf0});
            end
            checks++;
            if ({out_b, rise_b, fall_b, evt_b, ovf_b} !== {m_out, m_rise, m_fall, m_evt2, m_ovf2}) begin
                errors++;
                $display("FAIL random_fall cycle %0d: got %h expected %h", i, {out_b, rise_b, fall_b, evt_b, ovf_b}, {m_out, m_rise, m_fall, m_evt2, m_ovf2});
            end
        end
        clr_v = '0;
    endtask

    initial begin
        in_v  = RST_VAL;
        clr_v = '0;
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_sticky();
        test_mode();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
